// File: rtl/input_capture_if.sv
// Processor-side handshake bundle for the operand-entry stage.
interface input_capture_if;
    logic        read_req;
    logic [31:0] data_out;
    logic        data_valid;
    logic        waiting;
    logic        overrun;

    modport master (
        output read_req,
        input  data_out,
        input  data_valid,
        input  waiting,
        input  overrun
    );

    modport slave (
        input  read_req,
        output data_out,
        output data_valid,
        output waiting,
        output overrun
    );
endinterface

// File: rtl/input_capture.sv
// Debounced enter key plus switch capture into a one-entry register
// exposed to the processor through a valid/consume handshake.
module input_capture #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter bit          SIGN_EXT        = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic [14:0]       switches,
    input_capture_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD_DOWN,
        RELEASE_DB
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [15:0] cnt_inc;
    logic        fire;

    logic        enter_meta;
    logic        enter_sync;
    logic [14:0] sw_meta;
    logic [14:0] sw_sync;
    logic [31:0] sw_ext;

    logic [31:0] data_q;
    logic        valid_q;
    logic        waiting_q;
    logic        overrun_q;
    logic        cap;
    logic        drop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            enter_meta <= 1'b1;
            enter_sync <= 1'b1;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            enter_meta <= enter;
            enter_sync <= enter_meta;
            sw_meta    <= switches;
            sw_sync    <= sw_meta;
        end
    end

    assign cnt_inc = (cnt == DEBOUNCE_CYCLES) ? cnt : cnt + 16'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!enter_sync) begin
                    state_n = PRESS_DB;
                    cnt_n   = 16'd1;
                end
            end
            PRESS_DB: begin
                if (cnt == DEBOUNCE_CYCLES) begin
                    fire    = 1'b1;
                    state_n = HELD_DOWN;
                    cnt_n   = '0;
                end else if (enter_sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HELD_DOWN: begin
                cnt_n = '0;
                if (enter_sync) begin
                    state_n = RELEASE_DB;
                    cnt_n   = 16'd1;
                end
            end
            RELEASE_DB: begin
                if (cnt == DEBOUNCE_CYCLES) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (!enter_sync) begin
                    state_n = HELD_DOWN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign sw_ext = SIGN_EXT ? {{17{sw_sync[14]}}, sw_sync}
                             : {17'd0, sw_sync};

    // A capture into an empty register outranks a same-cycle read_req.
    assign cap  = fire & ~valid_q;
    assign drop = fire & valid_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            waiting_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (cap) begin
                data_q    <= sw_ext;
                valid_q   <= 1'b1;
                waiting_q <= 1'b0;
            end else begin
                if (bus.read_req) begin
                    valid_q <= 1'b0;
                end
                if (bus.read_req && !valid_q) begin
                    waiting_q <= 1'b1;
                end
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.waiting    = waiting_q;
    assign bus.overrun    = overrun_q;

endmodule
